ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter LAT, default 2, cycles from request start to ACCESS (legal range 1..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored.
REQ-003 SHALL have port CLK  input  1  system clock; single clock domain, all logic on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ramREN  input  1  read request, level, held until ACCESS.
REQ-006 SHALL have port ramWEN  input  1  write request, level, held until ACCESS.
REQ-007 SHALL have port ramaddr  input  32 (word_t)  byte address.
REQ-008 SHALL have port ramstore  input  32 (word_t)  write data.
REQ-009 SHALL have port ramstate  output  ramstate_t  FREE/BUSY/ACCESS/ERROR response.
REQ-010 SHALL have port ramload  output  32 (word_t)  read data.

Function
REQ-011 SHALL implement the memory end of the CPU-RAM handshake: consume ramREN/ramWEN/ramaddr/ramstore and drive ramstate/ramload.
REQ-012 SHALL use FSM states IDLE, WAIT, DONE; ramstate SHALL be combinational from state and inputs.
REQ-013 IDLE, no request: ramstate=FREE.
REQ-014 IDLE with exactly one of ramREN/ramWEN: ramstate=BUSY; capture op, addr, data; load counter LAT-1; go WAIT, or go DONE when LAT=1.
REQ-015 WAIT: ramstate=BUSY; decrement counter each cycle; at 0 go DONE.
REQ-016 DONE: ramstate=ACCESS for exactly one cycle; for a write, array word ramaddr[31:2] SHALL be written at the end of that cycle; for a read, ramload SHALL show the word during that cycle.
REQ-017 Request starting in cycle t with stable inputs SHALL see BUSY in cycles t..t+LAT-1 and ACCESS in cycle t+LAT.
REQ-018 After DONE, SHALL return to IDLE; a request still held in the next cycle SHALL start a new access.
REQ-019 A change of ramaddr, op or ramstore during WAIT/DONE SHALL abort the access without a write and restart it; the change cycle counts as cycle t.
REQ-020 A request dropped during WAIT SHALL abort the access: no write, go IDLE, ramstate=FREE that cycle.
REQ-021 ramREN and ramWEN both high in any state SHALL give ramstate=ERROR, perform no access, and set state IDLE.
REQ-022 Word index >= DEPTH_WORDS SHALL give ERROR instead of ACCESS in the DONE cycle, perform no write, and set ramload=0.
REQ-023 ramload SHALL be registered, updated only on a read ACCESS, and otherwise hold its last value.

Reset
REQ-024 nRST low at a rising edge SHALL set state IDLE, counter 0, captured registers 0, ramload 0, all array words 0.
REQ-025 Reset asserted mid-access SHALL discard the access with no write; with a request present the first cycle after reset SHALL show BUSY.

Configuration
REQ-026 Macro RAM_ALIGN_CHECK_EN SHALL control alignment checking.
REQ-027 With RAM_ALIGN_CHECK_EN defined, a request with ramaddr[1:0]!=0 SHALL be treated as REQ-021: ERROR, no access.
REQ-028 Without RAM_ALIGN_CHECK_EN, ramaddr[1:0] SHALL be ignored.

Structure
REQ-029 word_t and ramstate_t SHALL come from the existing core/mem type packages.
REQ-030 Constant RAM_LAT_DEFAULT=2 SHALL be added to mem_types_pkg.
REQ-031 The FSM state enum SHALL be local to the module.
REQ-032 Storage SHALL be sub-module ram_array: one write port, one read port, synchronous write, combinational read, sync clear.

Verification (LAT=2)
REQ-033 Write case: ramWEN=1, addr 0x10, data 0xDEADBEEF at t -> BUSY at t and t+1, ACCESS at t+2; then read of 0x10 -> ACCESS at t+2 with ramload=0xDEADBEEF.
REQ-034 Address-change case: read 0x20 with ramaddr changed to 0x24 at t+1 -> ACCESS at t+3 with the contents of 0x24.
REQ-035 Conflict case: ramREN=ramWEN=1 -> ERROR same cycle, no write; a following read of that address returns the old value.
REQ-036 Range case: DEPTH_WORDS=256, read 0x400 -> ERROR at t+2 and ramload=0.
REQ-037 Reset case: nRST low at t+1 of a write to 0x30 -> write suppressed; later read returns 0.
REQ-038 Alignment case (RAM_ALIGN_CHECK_EN): read 0x12 -> ERROR immediately; with macro undefined -> ACCESS with the word at 0x10.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by the CPU and its memory-side peers.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/mem_types_pkg.sv
// Memory handshake types and constants for the CPU-RAM interface.
package mem_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    localparam int RAM_LAT_DEFAULT = 2;

endpackage

// File: rtl/ram_array.sv
// Word storage for ram_responder: one synchronous write port, one
// combinational read port, synchronous whole-array clear.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          i_clk,
    input  logic          i_clr_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  word_t         i_wdata,
    input  logic [AW-1:0] i_raddr,
    output word_t         o_rdata
);

    word_t r_mem [DEPTH];

    // Clear every word on reset, otherwise commit the single write port.
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_responder.sv
// Memory side of the CPU-RAM handshake with LAT-cycle access latency.
// Optional alignment checking is enabled by defining RAM_ALIGN_CHECK_EN.
module ram_responder
    import cpu_types_pkg::*;
    import mem_types_pkg::*;
#(
    parameter int LAT         = RAM_LAT_DEFAULT,
    parameter int DEPTH_WORDS = 256
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output ramstate_t ramstate,
    output word_t     ramload
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_op_wr;
    logic [29:0] r_widx;
    word_t       r_data;
    word_t       r_ramload;

    state_t      w_next_state;
    state_t      w_start_state;
    ramstate_t   w_ramstate;
    logic        w_capture;
    logic [3:0]  w_cnt_next;
    logic        w_we;
    logic        w_req_one;
    logic        w_req_any;
    logic        w_misalign;
    logic        w_err_req;
    logic        w_changed;
    logic        w_cur_oor;
    logic        w_next_oor;
    logic        w_next_op_wr;
    logic [29:0] w_next_widx;
    word_t       w_rdata;

    assign w_req_any = ramREN | ramWEN;
    assign w_req_one = ramREN ^ ramWEN;

`ifdef RAM_ALIGN_CHECK_EN
    assign w_misalign = w_req_any & (ramaddr[1:0] != 2'b00);
`else
    logic w_unused_lsb;
    assign w_misalign   = 1'b0;
    assign w_unused_lsb = ^ramaddr[1:0];
`endif

    assign w_err_req     = (ramREN & ramWEN) | w_misalign;
    assign w_changed     = (ramaddr[31:2] != r_widx) | (ramWEN != r_op_wr) | (ramstore != r_data);
    assign w_start_state = (LAT == 1) ? DONE : WAIT;

    // Next-state and handshake response; an input change restarts the access.
    always_comb begin
        w_next_state = r_state;
        w_ramstate   = FREE;
        w_capture    = 1'b0;
        w_cnt_next   = r_cnt;
        w_we         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_err_req) begin
                    w_ramstate = ERROR;
                    w_cnt_next = 4'd0;
                end else if (w_req_one) begin
                    w_ramstate   = BUSY;
                    w_capture    = 1'b1;
                    w_cnt_next   = CNT_INIT;
                    w_next_state = w_start_state;
                end else begin
                    w_ramstate = FREE;
                    w_cnt_next = 4'd0;
                end
            end
            WAIT: begin
                if (w_err_req) begin
                    w_ramstate   = ERROR;
                    w_cnt_next   = 4'd0;
                    w_next_state = IDLE;
                end else if (!w_req_any) begin
                    w_ramstate   = FREE;
                    w_cnt_next   = 4'd0;
                    w_next_state = IDLE;
                end else if (w_changed) begin
                    w_ramstate   = BUSY;
                    w_capture    = 1'b1;
                    w_cnt_next   = CNT_INIT;
                    w_next_state = w_start_state;
                end else if (r_cnt <= 4'd1) begin
                    w_ramstate   = BUSY;
                    w_cnt_next   = 4'd0;
                    w_next_state = DONE;
                end else begin
                    w_ramstate   = BUSY;
                    w_cnt_next   = r_cnt - 4'd1;
                    w_next_state = WAIT;
                end
            end
            DONE: begin
                if (w_err_req) begin
                    w_ramstate   = ERROR;
                    w_cnt_next   = 4'd0;
                    w_next_state = IDLE;
                end else if (!w_req_any) begin
                    w_ramstate   = FREE;
                    w_cnt_next   = 4'd0;
                    w_next_state = IDLE;
                end else if (w_changed) begin
                    w_ramstate   = BUSY;
                    w_capture    = 1'b1;
                    w_cnt_next   = CNT_INIT;
                    w_next_state = w_start_state;
                end else if (w_cur_oor) begin
                    w_ramstate   = ERROR;
                    w_cnt_next   = 4'd0;
                    w_next_state = IDLE;
                end else begin
                    w_ramstate   = ACCESS;
                    w_we         = r_op_wr;
                    w_cnt_next   = 4'd0;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_ramstate   = FREE;
                w_cnt_next   = 4'd0;
                w_next_state = IDLE;
            end
        endcase
    end

    // The read word is fetched on the edge entering DONE so that the
    // registered ramload already holds it throughout the ACCESS cycle.
    assign w_next_widx  = w_capture ? ramaddr[31:2] : r_widx;
    assign w_next_op_wr = w_capture ? ramWEN : r_op_wr;
    assign w_next_oor   = ({2'b00, w_next_widx} >= 32'(DEPTH_WORDS));
    assign w_cur_oor    = ({2'b00, r_widx} >= 32'(DEPTH_WORDS));

    // FSM state, latency counter and captured request.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_op_wr <= 1'b0;
            r_widx  <= 30'd0;
            r_data  <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_op_wr <= ramWEN;
                r_widx  <= ramaddr[31:2];
                r_data  <= ramstore;
            end
        end
    end

    // Read data register: out-of-range accesses present zero.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_ramload <= '0;
        end else if ((w_next_state == DONE) && w_next_oor) begin
            r_ramload <= '0;
        end else if ((w_next_state == DONE) && !w_next_op_wr) begin
            r_ramload <= w_rdata;
        end
    end

    ram_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .i_clk   (CLK),
        .i_clr_n (nRST),
        .i_we    (w_we),
        .i_waddr (r_widx[AW-1:0]),
        .i_wdata (r_data),
        .i_raddr (w_next_widx[AW-1:0]),
        .o_rdata (w_rdata)
    );

    assign ramstate = w_ramstate;
    assign ramload  = r_ramload;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder (LAT=2, DEPTH_WORDS=256).
module tb_ram_responder;
    import cpu_types_pkg::*;
    import mem_types_pkg::*;

    typedef struct packed {
        logic [1:0]  st;
        logic        chk;
        logic [31:0] ld;
        logic [15:0] tag;
    } exp_t;

    logic      CLK;
    logic      nRST;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    ramstate_t ramstate;
    word_t     ramload;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] tag_cnt;
    int          total;
    int          bad;

    ram_responder #(.LAT(2), .DEPTH_WORDS(256)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramstate (ramstate),
        .ramload  (ramload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle of inputs and queue the response expected in that cycle.
    task automatic drive(input logic rn, input logic ren, input logic wen,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] st, input logic chk, input logic [31:0] ld);
        @(posedge CLK);
        #1;
        nRST     = rn;
        ramREN   = ren;
        ramWEN   = wen;
        ramaddr  = a;
        ramstore = d;
        sb.push_back('{st: st, chk: chk, ld: ld, tag: tag_cnt});
        tag_cnt  = tag_cnt + 16'd1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] st, input logic chk, input logic [31:0] ld);
        drive(1'b1, 1'b1, 1'b0, a, 32'h0, st, chk, ld);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] st);
        drive(1'b1, 1'b0, 1'b1, a, d, st, 1'b0, 32'h0);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 1'b0, 32'h0);
    endtask

    // Monitor: compare each presented response against the queued expectation.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total = total + 1;
            if (ramstate !== e.st) begin
                bad = bad + 1;
                $display("FAIL ramstate tag=%0d got=%0d want=%0d", e.tag, ramstate, e.st);
            end
            if (e.chk) begin
                total = total + 1;
                if (ramload !== e.ld) begin
                    bad = bad + 1;
                    $display("FAIL ramload tag=%0d got=%h want=%h", e.tag, ramload, e.ld);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        tag_cnt  = 16'd0;
        nRST     = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0;
        ramstore = 32'h0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // reset state
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 1'b1, 32'h0);

        // write 0x10 then read it back
        wr(32'h10, 32'hDEADBEEF, BUSY);
        wr(32'h10, 32'hDEADBEEF, BUSY);
        wr(32'h10, 32'hDEADBEEF, ACCESS);
        idle();
        rd(32'h10, BUSY, 1'b0, 32'h0);
        rd(32'h10, BUSY, 1'b0, 32'h0);
        rd(32'h10, ACCESS, 1'b1, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 1'b1, 32'hDEADBEEF);

        // address change mid-access restarts on the new address
        for (int k = 0; k < 2; k++) begin
            wr(k == 0 ? 32'h20 : 32'h24, k == 0 ? 32'h33334444 : 32'h11112222, BUSY);
            wr(k == 0 ? 32'h20 : 32'h24, k == 0 ? 32'h33334444 : 32'h11112222, BUSY);
            wr(k == 0 ? 32'h20 : 32'h24, k == 0 ? 32'h33334444 : 32'h11112222, ACCESS);
            idle();
        end
        rd(32'h20, BUSY, 1'b0, 32'h0);
        rd(32'h24, BUSY, 1'b0, 32'h0);
        rd(32'h24, BUSY, 1'b0, 32'h0);
        rd(32'h24, ACCESS, 1'b1, 32'h11112222);
        idle();

        // conflict in IDLE and during WAIT: ERROR, no write
        drive(1'b1, 1'b1, 1'b1, 32'h10, 32'hCAFEF00D, ERROR, 1'b0, 32'h0);
        idle();
        wr(32'h10, 32'hCAFEF00D, BUSY);
        drive(1'b1, 1'b1, 1'b1, 32'h10, 32'hCAFEF00D, ERROR, 1'b0, 32'h0);
        idle();
        // request dropped during WAIT: FREE, no write
        wr(32'h10, 32'h99999999, BUSY);
        idle();
        rd(32'h10, BUSY, 1'b0, 32'h0);
        rd(32'h10, BUSY, 1'b0, 32'h0);
        rd(32'h10, ACCESS, 1'b1, 32'hDEADBEEF);
        idle();

        // last in-range word, then first out-of-range word
        wr(32'h3FC, 32'h55AA55AA, BUSY);
        wr(32'h3FC, 32'h55AA55AA, BUSY);
        wr(32'h3FC, 32'h55AA55AA, ACCESS);
        idle();
        rd(32'h400, BUSY, 1'b0, 32'h0);
        rd(32'h400, BUSY, 1'b0, 32'h0);
        rd(32'h400, ERROR, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 1'b1, 32'h0);

        // held read repeats the access back to back
        for (int k = 0; k < 2; k++) begin
            rd(32'h3FC, BUSY, 1'b0, 32'h0);
            rd(32'h3FC, BUSY, 1'b0, 32'h0);
            rd(32'h3FC, ACCESS, 1'b1, 32'h55AA55AA);
        end
        idle();

        // misaligned read
`ifdef RAM_ALIGN_CHECK_EN
        rd(32'h12, ERROR, 1'b0, 32'h0);
        idle();
`else
        rd(32'h12, BUSY, 1'b0, 32'h0);
        rd(32'h12, BUSY, 1'b0, 32'h0);
        rd(32'h12, ACCESS, 1'b1, 32'hDEADBEEF);
        idle();
`endif

        // store data change restarts the write
        wr(32'h10, 32'h00000001, BUSY);
        wr(32'h10, 32'h00000002, BUSY);
        wr(32'h10, 32'h00000002, BUSY);
        wr(32'h10, 32'h00000002, ACCESS);
        idle();
        rd(32'h10, BUSY, 1'b0, 32'h0);
        rd(32'h10, BUSY, 1'b0, 32'h0);
        rd(32'h10, ACCESS, 1'b1, 32'h00000002);
        idle();

        // reset mid-write: suppressed, BUSY right after, array cleared
        wr(32'h30, 32'h77777777, BUSY);
        drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h77777777, BUSY, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h30, 32'h77777777, BUSY, 1'b1, 32'h0);
        idle();
        rd(32'h30, BUSY, 1'b0, 32'h0);
        rd(32'h30, BUSY, 1'b0, 32'h0);
        rd(32'h30, ACCESS, 1'b1, 32'h0);
        idle();
        rd(32'h10, BUSY, 1'b0, 32'h0);
        rd(32'h10, BUSY, 1'b0, 32'h0);
        rd(32'h10, ACCESS, 1'b1, 32'h0);
        idle();

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge CLK);
        end
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain got=%0d pending want=0", sb.size());
        end
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
